// File: rtl/irq_sched.sv
// Interrupt scheduler: 8 sources, pending/mask/in-service registers, fixed-priority
// arbitration with strict nesting, single-vector req/ack handshake to the CPU.
module irq_sched #(
  parameter logic [15:0] ADR_PEND  = 16'd40,
  parameter logic [15:0] ADR_FORCE = 16'd41,
  parameter logic [15:0] ADR_ISR   = 16'd42,
  parameter logic [15:0] ADR_EOI   = 16'd43,
  parameter logic [15:0] ADR_MASK  = 16'd50,
  parameter logic [15:0] ADR_CTRL  = 16'd51,
  parameter logic [7:0]  LEVEL     = 8'h00
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic [7:0]  irq_in,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic [15:0] mem_addr,
  input  logic [15:0] dout,
  output logic [15:0] io_din,
  output logic        irq_req,
  output logic [2:0]  irq_vec,
  input  logic        irq_ack
);

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] s1_q, s_q, sd_q;
  logic [7:0] pend_q, pend_d, mask_q, isr_q, isr_d;
  logic       gie_q;

  logic [7:0] edge_det, eff_pend, cand, pend_set, pend_clr, ack_oh, eoi_oh;
  logic [2:0] best, top;
  logic       eligible, req_live, ack_take;
  logic       wr_pend, wr_force, wr_eoi, wr_mask, wr_ctrl;
  logic       unused_ok;

  assign unused_ok = &{1'b0, io_rd, dout[15:8]};

  function automatic logic [2:0] msb_idx(input logic [7:0] v);
    msb_idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (v[i]) msb_idx = 3'(i);
  endfunction

  assign wr_pend  = io_wr && (mem_addr == ADR_PEND);
  assign wr_force = io_wr && (mem_addr == ADR_FORCE);
  assign wr_eoi   = io_wr && (mem_addr == ADR_EOI);
  assign wr_mask  = io_wr && (mem_addr == ADR_MASK);
  assign wr_ctrl  = io_wr && (mem_addr == ADR_CTRL);

  // Level sources bypass the pend register; pend only holds their forced part.
  assign edge_det = s_q & ~sd_q;
  assign eff_pend = pend_q | (s_q & LEVEL);
  assign cand     = eff_pend & mask_q & {8{gie_q}};
  assign best     = msb_idx(cand);
  assign top      = msb_idx(isr_q);
  assign eligible = (|cand) && ((isr_q == 8'd0) || (best > top));

  // The request is withdrawn the moment its candidate bit drops.
  assign req_live = (state_q == S_REQ) && cand[vec_q];
  assign ack_take = req_live && irq_ack;
  assign irq_req  = req_live;
  assign irq_vec  = vec_q;

  assign ack_oh   = ack_take ? (8'h01 << vec_q) : 8'h00;
  assign eoi_oh   = (wr_eoi && (isr_q != 8'd0)) ? (8'h01 << top) : 8'h00;
  assign pend_set = (edge_det & ~LEVEL) | (wr_force ? dout[7:0] : 8'h00);
  assign pend_clr = (wr_pend ? dout[7:0] : 8'h00) | ack_oh;
  assign pend_d   = (pend_q & ~pend_clr) | pend_set;
  assign isr_d    = (isr_q & ~eoi_oh) | ack_oh;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      S_IDLE: if (eligible) begin
        vec_d   = best;
        state_d = S_REQ;
      end
      S_REQ: if (!req_live || irq_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    io_din = 16'd0;
    case (mem_addr)
      ADR_PEND: io_din = {8'd0, eff_pend};
      ADR_ISR:  io_din = {8'd0, isr_q};
      ADR_MASK: io_din = {8'd0, mask_q};
      ADR_CTRL: io_din = {15'd0, gie_q};
      default:  io_din = 16'd0;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      s1_q    <= 8'd0;
      s_q     <= 8'd0;
      sd_q    <= 8'd0;
      pend_q  <= 8'd0;
      mask_q  <= 8'd0;
      isr_q   <= 8'd0;
      gie_q   <= 1'b0;
      state_q <= S_IDLE;
      vec_q   <= 3'd0;
    end else begin
      s1_q    <= irq_in;
      s_q     <= s1_q;
      sd_q    <= s_q;
      pend_q  <= pend_d;
      isr_q   <= isr_d;
      state_q <= state_d;
      vec_q   <= vec_d;
      if (wr_mask) mask_q <= dout[7:0];
      if (wr_ctrl) gie_q  <= dout[0];
    end
  end

endmodule

// File: tb/tb_irq_sched.sv
// Directed bench for irq_sched: latency, priority, nesting, withdraw, set/clear
// collision, level source and asynchronous reset.
module tb_irq_sched;

  localparam logic [15:0] A_PEND = 16'd40, A_FORCE = 16'd41, A_ISR = 16'd42,
                          A_EOI = 16'd43, A_MASK = 16'd50, A_CTRL = 16'd51;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic [7:0]  irq_in = 8'd0;
  logic        io_wr = 1'b0, io_rd = 1'b0, irq_ack = 1'b0;
  logic [15:0] mem_addr = 16'd0, dout = 16'd0;
  logic [15:0] io_din;
  logic        irq_req;
  logic [2:0]  irq_vec;

  int checks = 0;
  int errors = 0;

  irq_sched #(.LEVEL(8'h01)) dut (
    .clk(clk), .resetq(resetq), .irq_in(irq_in), .io_wr(io_wr), .io_rd(io_rd),
    .mem_addr(mem_addr), .dout(dout), .io_din(io_din), .irq_req(irq_req),
    .irq_vec(irq_vec), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic io_write(input logic [15:0] a, input logic [15:0] d);
    io_wr = 1'b1; mem_addr = a; dout = d;
    @(negedge clk);
    io_wr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    mem_addr = a;
    #1;
    chk(tag, io_din, exp);
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int max);
    int n = 0;
    while (!irq_req && n < max) begin
      step();
      n++;
    end
    chk(tag, {15'd0, irq_req}, 16'd1);
  endtask

  task automatic req_chk(input string tag, input logic r, input logic [2:0] v);
    chk(tag, {12'd0, r, v}, {12'd0, r, v & {3{r}}} | {12'd0, 1'b0, irq_vec & {3{~r}}});
  endtask

  initial begin
    repeat (3) step();
    resetq = 1'b1;
    step();

    // reset state
    chk("rst_req", {15'd0, irq_req}, 16'd0);
    chk("rst_vec", {13'd0, irq_vec}, 16'd0);
    rd_chk("rst_pend", A_PEND, 16'd0);
    rd_chk("rst_isr",  A_ISR,  16'd0);
    rd_chk("rst_mask", A_MASK, 16'd0);
    rd_chk("rst_ctrl", A_CTRL, 16'd0);

    // edge, basic: 4-edge latency
    io_write(A_MASK, 16'h0080);
    io_write(A_CTRL, 16'h0001);
    rd_chk("mask_rd", A_MASK, 16'h0080);
    rd_chk("ctrl_rd", A_CTRL, 16'h0001);
    irq_in = 8'h80; step(); irq_in = 8'h00;
    chk("lat_e1", {15'd0, irq_req}, 16'd0);
    step(); chk("lat_e2", {15'd0, irq_req}, 16'd0);
    step(); chk("lat_e3", {15'd0, irq_req}, 16'd0);
    rd_chk("edge_pend", A_PEND, 16'h0080);
    step(); chk("lat_e4", {15'd0, irq_req}, 16'd1);
    chk("edge_vec", {13'd0, irq_vec}, 16'd7);
    ack_pulse();
    chk("ack_drop", {15'd0, irq_req}, 16'd0);
    rd_chk("ack_isr",  A_ISR,  16'h0080);
    rd_chk("ack_pend", A_PEND, 16'h0000);
    rd_chk("force_rd0", A_FORCE, 16'h0000);
    io_write(A_EOI, 16'h0000);
    rd_chk("eoi_isr", A_ISR, 16'h0000);

    // priority
    io_write(A_MASK, 16'h00FF);
    io_write(A_FORCE, 16'h0012);
    chk("frc_k1", {15'd0, irq_req}, 16'd0);
    step();
    chk("pri_req", {15'd0, irq_req}, 16'd1);
    chk("pri_vec4", {13'd0, irq_vec}, 16'd4);
    ack_pulse();
    rd_chk("pri_isr", A_ISR, 16'h0010);
    step(); step();
    chk("pri_block", {15'd0, irq_req}, 16'd0);
    io_write(A_EOI, 16'h0000);
    step();
    chk("pri_req1", {15'd0, irq_req}, 16'd1);
    chk("pri_vec1", {13'd0, irq_vec}, 16'd1);
    ack_pulse();
    rd_chk("pri_isr1", A_ISR, 16'h0002);
    io_write(A_EOI, 16'h0000);
    rd_chk("pri_isr0", A_ISR, 16'h0000);

    // nesting
    io_write(A_FORCE, 16'h0004);
    step();
    chk("nest_vec2", {12'd0, irq_req, irq_vec}, 16'h000A);
    ack_pulse();
    rd_chk("nest_isr4", A_ISR, 16'h0004);
    io_write(A_FORCE, 16'h0040);
    step();
    chk("nest_vec6", {12'd0, irq_req, irq_vec}, 16'h000E);
    ack_pulse();
    rd_chk("nest_isr44", A_ISR, 16'h0044);
    io_write(A_EOI, 16'h0000);
    rd_chk("nest_eoi1", A_ISR, 16'h0004);
    io_write(A_EOI, 16'h0000);
    rd_chk("nest_eoi2", A_ISR, 16'h0000);
    chk("nest_idle", {15'd0, irq_req}, 16'd0);

    // withdraw
    io_write(A_FORCE, 16'h0008);
    step();
    chk("wd_vec3", {12'd0, irq_req, irq_vec}, 16'h000B);
    io_write(A_MASK, 16'h0000);
    chk("wd_drop", {15'd0, irq_req}, 16'd0);
    rd_chk("wd_isr", A_ISR, 16'h0000);
    step();
    chk("wd_stay", {15'd0, irq_req}, 16'd0);
    io_write(A_MASK, 16'h00FF);
    step();
    chk("wd_rereq", {12'd0, irq_req, irq_vec}, 16'h000B);
    ack_pulse();
    io_write(A_EOI, 16'h0000);
    rd_chk("wd_isr0", A_ISR, 16'h0000);

    // collision: edge on 5 and W1C of bit 5 on the same clock edge
    io_write(A_CTRL, 16'h0000);
    irq_in = 8'h20; step(); step();
    io_write(A_PEND, 16'h0020);
    rd_chk("coll_pend", A_PEND, 16'h0020);
    irq_in = 8'h00;
    io_write(A_PEND, 16'h0020);
    rd_chk("w1c_pend", A_PEND, 16'h0000);

    // level source 0
    io_write(A_CTRL, 16'h0001);
    irq_in = 8'h01;
    wait_req("lvl_req", 10);
    chk("lvl_vec", {13'd0, irq_vec}, 16'd0);
    rd_chk("lvl_pend", A_PEND, 16'h0001);
    ack_pulse();
    rd_chk("lvl_isr", A_ISR, 16'h0001);
    step();
    chk("lvl_block", {15'd0, irq_req}, 16'd0);
    io_write(A_EOI, 16'h0000);
    wait_req("lvl_rereq", 10);
    chk("lvl_vec2", {13'd0, irq_vec}, 16'd0);

    // async reset mid-REQ
    io_write(A_FORCE, 16'h0080);
    #2;
    resetq = 1'b0;
    #1;
    chk("ar_req", {15'd0, irq_req}, 16'd0);
    chk("ar_vec", {13'd0, irq_vec}, 16'd0);
    rd_chk("ar_pend", A_PEND, 16'h0000);
    rd_chk("ar_isr",  A_ISR,  16'h0000);
    rd_chk("ar_mask", A_MASK, 16'h0000);
    rd_chk("ar_ctrl", A_CTRL, 16'h0000);
    irq_in = 8'h00;
    step();
    resetq = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
